md_buffer: RTL and testbench
============================

Name: md_buffer

Overview:
- Parametrised successor to the single-register memory data latch; sits between data memory read port and datapath B-input mux.
- Buffers up to DEPTH memory read returns in a FIFO, applies per-access load mode (word / half, zero or sign extend) at capture time.
- Presents head entry to datapath with valid/ready handshake; flags overflow on dropped returns.

Parameters:
- WIDTH, 16, data word width; must be even, >= 8; HALF = WIDTH/2.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CW, $clog2(DEPTH)+1, width of count output (derived localparam, not overridable).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- rd_data  input  WIDTH  memory read data (RD).
- rd_valid  input  1  rd_data valid this cycle; push request.
- rd_mode  input  2  load mode for this push: 00 word, 01 low half zero-ext, 10 low half sign-ext, 11 high half zero-ext (shifted to low half).
- clear  input  1  synchronous flush.
- inb  output  WIDTH  head entry to datapath; 0 when empty.
- inb_valid  output  1  head entry valid (= !empty).
- inb_ready  input  1  datapath consumes head this cycle.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  CW  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a push was dropped.

Behaviour:
- Reset (reset=1 at edge): wr_ptr=rd_ptr=0, count=0, overflow=0; after edge inb=0, inb_valid=0, empty=1, full=0. Storage contents need not be cleared.
- Priority per edge: reset > clear > push/pop. clear: same as reset for pointers/count/overflow; concurrent push and pop ignored.
- pop = inb_valid & inb_ready. push_ok = rd_valid & (!full | pop).
- Push stores transformed data at wr_ptr, wr_ptr+1 mod DEPTH. Transform: 00 rd_data; 01 {HALF'0, rd_data[HALF-1:0]}; 10 {HALF{rd_data[HALF-1]}, rd_data[HALF-1:0]}; 11 {HALF'0, rd_data[WIDTH-1:HALF]}.
- Pop advances rd_ptr mod DEPTH. Pointers wrap without gap; full/empty derive from count, not pointer compare.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Latency: push at edge N -> visible on inb/inb_valid after edge N (one cycle), when FIFO was empty. No combinational path rd_data -> inb.
- inb is combinational from head storage and empty flag (inb = empty ? 0 : mem[rd_ptr]).
- Full with simultaneous pop and push: both occur, count stays DEPTH, no overflow.
- Full, rd_valid=1, no pop: data dropped, overflow set; stays 1 until reset or clear.
- Empty with inb_ready=1: no pop, no state change.
- full, empty, count, overflow are registered or derived from registered state only.

Optional Feature:
- Macro MD_BUFFER_PARITY_EN.
- Defined: adds input rd_par (1 bit, even parity over rd_data) and output par_err (1 bit). Parity check done on raw rd_data at push; mismatch bit stored per entry alongside data. par_err = inb_valid & stored mismatch of head entry; 0 when empty; cleared with entry on pop/clear/reset.
- Not defined: rd_par and par_err ports absent; no extra storage.

Test Plan:
- Reset then idle: reset=1 two cycles -> inb=0, inb_valid=0, empty=1, count=0, overflow=0.
- Mode transform: push 16'hF080 with modes 00,01,10,11 (inb_ready=0) -> pops in order give 16'hF080, 16'h0080, 16'hFF80, 16'h00F0.
- Fill and overflow: push 1,2,3,4,5 back-to-back, inb_ready=0 -> full=1 after 4th, count=4, overflow=1 after 5th; pops return 1,2,3,4; empty=1, overflow stays 1 until clear.
- Full simultaneous push/pop: with FIFO holding 1..4, rd_data=9 rd_valid=1 inb_ready=1 one cycle -> count=4, overflow=0; subsequent pops 2,3,4,9.
- Wrap-around: 10 cycles continuous push k=1..10 with inb_ready=1 -> each value on inb one cycle after push, count never exceeds 1, order preserved across pointer wrap.
- Clear vs push: FIFO holding 2 entries, clear=1 with rd_valid=1 same cycle -> count=0, empty=1, overflow=0, pushed data not stored; (parity build) push 16'h0001 with rd_par=0 -> par_err=1 while at head.

Source files
------------

// File: rtl/md_buffer.sv
// md_buffer: FIFO of memory read returns with per-access load-mode transform, feeding the datapath B-input mux.
// Optional per-entry parity check is enabled by defining MD_BUFFER_PARITY_EN (adds rd_par input and par_err output).
module md_buffer #(
   parameter  int WIDTH = 16,
   parameter  int DEPTH = 4,
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] rd_data,
   input  logic             rd_valid,
   input  logic [1:0]       rd_mode,
   input  logic             clear,
   output logic [WIDTH-1:0] inb,
   output logic             inb_valid,
   input  logic             inb_ready,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count,
   output logic             overflow
`ifdef MD_BUFFER_PARITY_EN
   ,
   input  logic             rd_par,
   output logic             par_err
`endif
);

   localparam int HALF = WIDTH / 2;
   localparam int PW   = $clog2(DEPTH);

   // Each entry carries the transformed word plus, in the parity build, its mismatch flag in the top bit.
`ifdef MD_BUFFER_PARITY_EN
   localparam int EW = WIDTH + 1;
`else
   localparam int EW = WIDTH;
`endif

   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [PW-1:0] PTR_ZERO = PW'(0);

   function automatic logic [WIDTH-1:0] load_xform(input logic [WIDTH-1:0] d, input logic [1:0] m);
      logic [WIDTH-1:0] r;
      case (m)
         2'b00:   r = d;
         2'b01:   r = {{HALF{1'b0}}, d[HALF-1:0]};
         2'b10:   r = {{HALF{d[HALF-1]}}, d[HALF-1:0]};
         2'b11:   r = {{HALF{1'b0}}, d[WIDTH-1:HALF]};
         default: r = d;
      endcase
      return r;
   endfunction

`ifdef MD_BUFFER_PARITY_EN
   // Even parity: data bits plus parity bit must XOR to zero.
   function automatic logic par_mismatch(input logic [WIDTH-1:0] d, input logic p);
      return (^d) ^ p;
   endfunction
`endif

   logic [EW-1:0]    mem_r [DEPTH];
   logic [PW-1:0]    wr_ptr_r;
   logic [PW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic             overflow_r;
   logic             full_s;
   logic             empty_s;
   logic             pop_s;
   logic             push_ok_s;
   logic [EW-1:0]    wr_entry_s;
   logic [EW-1:0]    head_s;
   logic [WIDTH-1:0] inb_s;

   assign full_s    = (count_r == CNT_FULL);
   assign empty_s   = (count_r == CNT_ZERO);
   assign pop_s     = !empty_s && inb_ready;
   assign push_ok_s = rd_valid && (!full_s || pop_s);
   assign head_s    = mem_r[rd_ptr_r];

`ifdef MD_BUFFER_PARITY_EN
   assign wr_entry_s = {par_mismatch(rd_data, rd_par), load_xform(rd_data, rd_mode)};
   assign par_err    = !empty_s && head_s[WIDTH];
`else
   assign wr_entry_s = load_xform(rd_data, rd_mode);
`endif

   // Head presentation: zero whenever nothing is buffered.
   always_comb begin
      inb_s = {WIDTH{1'b0}};
      if (empty_s) begin
         inb_s = {WIDTH{1'b0}};
      end else begin
         inb_s = head_s[WIDTH-1:0];
      end
   end

   // Entry storage; not reset, occupancy alone decides what is meaningful.
   always_ff @(posedge clk) begin
      if (!reset && !clear && push_ok_s) begin
         mem_r[wr_ptr_r] <= wr_entry_s;
      end
   end

   // Pointers, occupancy and sticky overflow; flush has priority over traffic.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         wr_ptr_r   <= PTR_ZERO;
         rd_ptr_r   <= PTR_ZERO;
         count_r    <= CNT_ZERO;
         overflow_r <= 1'b0;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         if (push_ok_s && !pop_s) begin
            count_r <= count_r + CNT_ONE;
         end else if (pop_s && !push_ok_s) begin
            count_r <= count_r - CNT_ONE;
         end
         if (rd_valid && !push_ok_s) begin
            overflow_r <= 1'b1;
         end
      end
   end

   assign inb       = inb_s;
   assign inb_valid = !empty_s;
   assign full      = full_s;
   assign empty     = empty_s;
   assign count     = count_r;
   assign overflow  = overflow_r;

endmodule

// File: tb/tb_md_buffer.sv
// Directed self-checking bench for md_buffer (default parameters); parity checks compile in with MD_BUFFER_PARITY_EN.
module tb_md_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] rd_data;
   logic        rd_valid;
   logic [1:0]  rd_mode;
   logic        clear;
   logic [15:0] inb;
   logic        inb_valid;
   logic        inb_ready;
   logic        full;
   logic        empty;
   logic [2:0]  count;
   logic        overflow;
`ifdef MD_BUFFER_PARITY_EN
   logic        rd_par;
   logic        par_err;
`endif

   int checks_s = 0;
   int errors_s = 0;

   md_buffer #(.WIDTH(16), .DEPTH(4)) dut (
      .clk(clk), .reset(reset), .rd_data(rd_data), .rd_valid(rd_valid), .rd_mode(rd_mode),
      .clear(clear), .inb(inb), .inb_valid(inb_valid), .inb_ready(inb_ready), .full(full),
      .empty(empty), .count(count), .overflow(overflow)
`ifdef MD_BUFFER_PARITY_EN
      , .rd_par(rd_par), .par_err(par_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_s++;
      if (obs !== exp) begin
         errors_s++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] d, input logic [1:0] m);
      rd_data  = d;
      rd_mode  = m;
      rd_valid = 1'b1;
      step();
      rd_valid = 1'b0;
   endtask

   task automatic pop_expect(input string tag, input logic [15:0] exp);
      check_eq(tag, {16'h0000, inb}, {16'h0000, exp});
      check_eq({tag, "_valid"}, {31'd0, inb_valid}, 32'd1);
      inb_ready = 1'b1;
      step();
      inb_ready = 1'b0;
   endtask

   logic [15:0] mode_exp [4];
   logic [15:0] tail_exp [4];

   initial begin
      reset = 1'b1; rd_data = 16'h0000; rd_valid = 1'b0; rd_mode = 2'b00;
      clear = 1'b0; inb_ready = 1'b0;
`ifdef MD_BUFFER_PARITY_EN
      rd_par = 1'b0;
`endif
      // Reset then idle
      step(); step();
      reset = 1'b0;
      check_eq("rst_inb", {16'h0000, inb}, 32'h0);
      check_eq("rst_valid", {31'd0, inb_valid}, 32'd0);
      check_eq("rst_empty", {31'd0, empty}, 32'd1);
      check_eq("rst_full", {31'd0, full}, 32'd0);
      check_eq("rst_count", {29'd0, count}, 32'd0);
      check_eq("rst_ovf", {31'd0, overflow}, 32'd0);
      step();
      check_eq("idle_count", {29'd0, count}, 32'd0);

      // Mode transform
      mode_exp[0] = 16'hF080; mode_exp[1] = 16'h0080; mode_exp[2] = 16'hFF80; mode_exp[3] = 16'h00F0;
      for (int i = 0; i < 4; i++) push(16'hF080, 2'(i));
      check_eq("mode_full", {31'd0, full}, 32'd1);
      for (int i = 0; i < 4; i++) pop_expect($sformatf("mode%0d", i), mode_exp[i]);
      check_eq("mode_empty", {31'd0, empty}, 32'd1);

      // Fill and overflow
      for (int k = 1; k <= 5; k++) begin
         push(16'(k), 2'b00);
         if (k == 4) begin
            check_eq("fill_full", {31'd0, full}, 32'd1);
            check_eq("fill_count", {29'd0, count}, 32'd4);
            check_eq("fill_ovf_pre", {31'd0, overflow}, 32'd0);
         end
      end
      check_eq("fill_ovf", {31'd0, overflow}, 32'd1);
      check_eq("fill_count5", {29'd0, count}, 32'd4);
      for (int k = 1; k <= 4; k++) pop_expect($sformatf("fill_pop%0d", k), 16'(k));
      check_eq("fill_empty", {31'd0, empty}, 32'd1);
      check_eq("fill_empty_inb", {16'h0000, inb}, 32'h0);
      check_eq("fill_ovf_sticky", {31'd0, overflow}, 32'd1);
      clear = 1'b1; step(); clear = 1'b0;
      check_eq("clr_ovf", {31'd0, overflow}, 32'd0);

      // Full simultaneous push/pop
      for (int k = 1; k <= 4; k++) push(16'(k), 2'b00);
      rd_data = 16'h0009; rd_valid = 1'b1; inb_ready = 1'b1;
      step();
      rd_valid = 1'b0; inb_ready = 1'b0;
      check_eq("pp_count", {29'd0, count}, 32'd4);
      check_eq("pp_ovf", {31'd0, overflow}, 32'd0);
      tail_exp[0] = 16'd2; tail_exp[1] = 16'd3; tail_exp[2] = 16'd4; tail_exp[3] = 16'd9;
      for (int i = 0; i < 4; i++) pop_expect($sformatf("pp_pop%0d", i), tail_exp[i]);

      // Wrap-around streaming with consumer always ready
      inb_ready = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         rd_data = 16'(k); rd_valid = 1'b1;
         step();
         check_eq($sformatf("wrap_inb%0d", k), {16'h0000, inb}, k);
         check_eq($sformatf("wrap_cnt%0d", k), {29'd0, count}, 32'd1);
      end
      rd_valid = 1'b0;
      step();
      check_eq("wrap_empty", {31'd0, empty}, 32'd1);
      // Empty with ready asserted: nothing changes
      step();
      check_eq("empty_ready_cnt", {29'd0, count}, 32'd0);
      inb_ready = 1'b0;

      // Clear vs push
      push(16'h0011, 2'b00);
      push(16'h0022, 2'b00);
      check_eq("clr_pre_cnt", {29'd0, count}, 32'd2);
      clear = 1'b1; rd_data = 16'h0055; rd_valid = 1'b1;
      step();
      clear = 1'b0; rd_valid = 1'b0;
      check_eq("clr_cnt", {29'd0, count}, 32'd0);
      check_eq("clr_empty", {31'd0, empty}, 32'd1);
      check_eq("clr_ovf2", {31'd0, overflow}, 32'd0);
      step();
      check_eq("clr_nostore", {31'd0, inb_valid}, 32'd0);

`ifdef MD_BUFFER_PARITY_EN
      rd_par = 1'b0;
      push(16'h0001, 2'b00);
      rd_par = 1'b0;
      push(16'h0003, 2'b00);
      check_eq("par_err_head", {31'd0, par_err}, 32'd1);
      pop_expect("par_pop1", 16'h0001);
      check_eq("par_ok_head", {31'd0, par_err}, 32'd0);
      pop_expect("par_pop2", 16'h0003);
      check_eq("par_empty", {31'd0, par_err}, 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks_s, errors_s);
      $finish;
   end

endmodule
